// File: rtl/req_ack_4ph_rx_if.sv
// Bundle for the receive side of the 4-phase req/ack crossing.
// slave: receiver view (req/din/rdy in, ack/val/dout/err out).
interface req_ack_4ph_rx_if #(
  parameter int DW = 8
);
  logic          req;
  logic [DW-1:0] din;
  logic          ack;
  logic          val;
  logic          rdy;
  logic [DW-1:0] dout;
  logic          err;

  modport master (
    output req,
    output din,
    output rdy,
    input  ack,
    input  val,
    input  dout,
    input  err
  );

  modport slave (
    input  req,
    input  din,
    input  rdy,
    output ack,
    output val,
    output dout,
    output err
  );
endinterface

// File: rtl/req_ack_4ph_rx.sv
// 4-phase req/ack receiver: req sync, FIFO buffer, val/rdy out.
// Ports: clk_rx, rst_b (async low), bus (slave modport).
module req_ack_4ph_rx #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic            clk_rx,
  input  logic            rst_b,
  req_ack_4ph_rx_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic          r_req_m;
  logic          r_req_s;
  logic [1:0]    r_state;
  logic          r_ack;
  logic          r_err;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_nxt;
  logic          w_wr;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_set_err;

  // Space is judged on registered count only; a pop this
  // cycle frees a slot for writing only from next cycle.
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = !w_empty && bus.rdy;

  always_comb begin
    w_nxt     = r_state;
    w_wr      = 1'b0;
    w_set_err = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (r_req_s) begin
          if (!w_full) begin
            w_wr  = 1'b1;
            w_nxt = S_ACK;
          end else begin
            w_nxt = S_WAIT;
          end
        end
      end
      (r_state == S_WAIT): begin
        // req withdrawn before ack: transmitter broke protocol
        if (!r_req_s) begin
          w_set_err = 1'b1;
          w_nxt     = S_IDLE;
        end else if (!w_full) begin
          w_wr  = 1'b1;
          w_nxt = S_ACK;
        end
      end
      (r_state == S_ACK): begin
        if (!r_req_s) begin
          w_nxt = S_IDLE;
        end
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_rx or negedge rst_b) begin
    if (!rst_b) begin
      r_req_m <= 1'b0;
      r_req_s <= 1'b0;
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_req_m <= bus.req;
      r_req_s <= r_req_m;
      r_state <= w_nxt;
      r_ack   <= (w_nxt == S_ACK);
      r_err   <= r_err | w_set_err;
    end
  end

  always_ff @(posedge clk_rx or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= bus.din;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.ack  = r_ack;
  assign bus.err  = r_err;
  assign bus.val  = !w_empty;
  assign bus.dout = r_mem[r_rp];

endmodule

// File: tb/tb_req_ack_4ph_rx.sv
// Bench for req_ack_4ph_rx: directed + random handshakes,
// scoreboard queue of sent words checked on every pop.
module tb_req_ack_4ph_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int LIM   = 200;

  logic clk_rx = 1'b0;
  logic rst_b  = 1'b0;

  req_ack_4ph_rx_if #(.DW(DW)) bus();

  req_ack_4ph_rx #(
    .DW(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk_rx(clk_rx),
    .rst_b(rst_b),
    .bus(bus)
  );

  always #5 clk_rx = ~clk_rx;

  int n_pass = 0;
  int n_tot  = 0;
  logic [DW-1:0] sb[$];
  bit done = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_rx);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input bit lat,
                          input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack !== lvl && n < LIM);
    chk({nm, "_level"}, 32'(bus.ack), 32'(lvl));
    if (lat) chk({nm, "_latency"}, n, 3);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit lat);
    bus.din = d;
    bus.req = 1'b1;
    sb.push_back(d);
    wait_ack(1'b1, lat, "ack_rise");
    bus.req = 1'b0;
    wait_ack(1'b0, lat, "ack_fall");
  endtask

  task automatic drain();
    int n = 0;
    bus.rdy = 1'b1;
    while (bus.val && n < LIM) begin
      tick();
      n++;
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_val", 32'(bus.val), 0);
    bus.rdy = 1'b0;
  endtask

  // Monitor: pop check plus "val/dout hold until popped".
  logic          pv   = 1'b0;
  logic          pp   = 1'b0;
  logic          prst = 1'b0;
  logic [DW-1:0] pd   = '0;

  always @(negedge clk_rx) begin
    if (prst && rst_b && pv && !pp)
      chk("hold", 32'({bus.val, bus.dout}), 32'({1'b1, pd}));
    pp = 1'b0;
    if (rst_b && bus.val && bus.rdy) begin
      if (sb.size() == 0) chk("pop_unexpected", sb.size(), 1);
      else chk("pop_data", 32'(bus.dout), 32'(sb.pop_front()));
      pp = 1'b1;
    end
    pv   = bus.val;
    pd   = bus.dout;
    prst = rst_b;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: no finish after 1ms");
    $fatal(1);
  end

  initial begin
    bus.req = 1'b1;
    bus.din = 8'h3C;
    bus.rdy = 1'b0;
    rst_b   = 1'b0;
    repeat (3) tick();
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_val", 32'(bus.val), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst_b = 1'b1;
    sb.push_back(8'h3C);
    wait_ack(1'b1, 1'b1, "rel_ack_rise");
    chk("rel_dout", 32'(bus.dout), 32'h3C);
    bus.req = 1'b0;
    wait_ack(1'b0, 1'b1, "rel_ack_fall");
    drain();

    bus.din = 8'hA5;
    bus.req = 1'b1;
    sb.push_back(8'hA5);
    wait_ack(1'b1, 1'b1, "single_rise");
    chk("single_val", 32'(bus.val), 1);
    chk("single_dout", 32'(bus.dout), 32'hA5);
    bus.req = 1'b0;
    wait_ack(1'b0, 1'b1, "single_fall");
    drain();

    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    bus.din = 8'h33;
    bus.req = 1'b1;
    sb.push_back(8'h33);
    repeat (6) tick();
    chk("bp_wait_ack", 32'(bus.ack), 0);
    chk("bp_head", 32'(bus.dout), 32'h11);
    bus.rdy = 1'b1;
    tick();
    bus.rdy = 1'b0;
    chk("bp_ack_pop_edge", 32'(bus.ack), 0);
    tick();
    chk("bp_ack_after", 32'(bus.ack), 1);
    bus.req = 1'b0;
    wait_ack(1'b0, 1'b1, "bp_fall");
    drain();

    bus.rdy = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(i), 1'b1);
    drain();

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send(8'($urandom), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.rdy = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    drain();

    send(8'h66, 1'b1);
    send(8'h77, 1'b1);
    bus.din = 8'h88;
    bus.req = 1'b1;
    repeat (5) tick();
    chk("viol_ack", 32'(bus.ack), 0);
    bus.req = 1'b0;
    repeat (5) tick();
    chk("viol_err", 32'(bus.err), 1);
    chk("viol_ack_idle", 32'(bus.ack), 0);
    chk("viol_head", 32'(bus.dout), 32'h66);
    drain();
    send(8'h99, 1'b1);
    chk("viol_err_sticky", 32'(bus.err), 1);
    drain();

    send(8'hAA, 1'b1);
    bus.din = 8'hBB;
    bus.req = 1'b1;
    sb.push_back(8'hBB);
    wait_ack(1'b1, 1'b1, "mid_rise");
    rst_b = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(bus.ack), 0);
    chk("mid_rst_val", 32'(bus.val), 0);
    chk("mid_rst_err", 32'(bus.err), 0);
    sb.delete();
    repeat (2) tick();
    rst_b = 1'b1;
    sb.push_back(8'hBB);
    wait_ack(1'b1, 1'b1, "mid_rel_rise");
    chk("mid_rel_dout", 32'(bus.dout), 32'hBB);
    bus.req = 1'b0;
    wait_ack(1'b0, 1'b1, "mid_rel_fall");
    drain();

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/req_ack_4ph_rx.md
Name: req_ack_4ph_rx

Overview:
Receive side of the 4-phase req/ack clock-domain crossing. It sits directly downstream of the 4-phase transmitter and runs in the receiver clock domain. It synchronises the incoming req and captures the parallel data bus, which the transmitter holds stable while req is high. It buffers each word in a small FIFO, presents it to the local consumer on a val/rdy interface, and drives ack back to the transmitter. When the FIFO is full, ack is withheld so the transmitter is back-pressured.

Parameters:
DW, 8, data width in bits.
DEPTH, 2, FIFO entries; power of 2, minimum 2.

Ports:
clk_rx  input  1  receiver clock.
rst_b  input  1  asynchronous active-low reset.
req  input  1  4-phase request from the transmitter; asynchronous to clk_rx.
din  input  DW  data from the transmitter; stable whenever req is high.
ack  output  1  4-phase acknowledge to the transmitter; registered.
val  output  1  FIFO non-empty; dout is valid.
rdy  input  1  consumer ready; pop occurs when val & rdy.
dout  output  DW  FIFO head word.
err  output  1  sticky protocol error flag.

Behaviour:
- Reset (async assert, sync release): sync flops 0, ack 0, val 0, dout 0, err 0, FIFO storage and pointers 0, FSM in IDLE.
- Synchroniser: req passes through a 2-FF chain to give req_s. No logic samples raw req. din is sampled only when req_s=1.
- FSM (registered), ack = (state == ACK_HI):
  - IDLE:
    - req_s=1 and not full: write din into FIFO, go to ACK_HI.
    - req_s=1 and full: go to WAIT.
  - WAIT: ack stays 0.
    - req_s=0: set err=1, go to IDLE, nothing written.
    - Else, once not full: write din, go to ACK_HI.
  - ACK_HI: ack=1.
    - req_s=0: go to IDLE, so ack returns to 0 on the next edge.
    - req_s=1: stay in ACK_HI. Exactly one write per handshake.
- Latency:
  - req rising edge to ack high: 3 clk_rx edges when space is available (2 sync edges + 1 state edge).
  - val rises on the same edge as ack.
  - req fall to ack fall: 3 edges.
- FIFO:
  - Write pointer, read pointer and count; count width $clog2(DEPTH+1).
  - Pointers wrap modulo DEPTH.
  - Full = (count == DEPTH); empty = (count == 0).
  - "Space" for a write is judged on the registered full flag only. A pop in the same cycle does not free space for a write until the next cycle.
  - Simultaneous write and pop when non-empty and non-full: count unchanged, both pointers advance.
  - Pop when empty is impossible because val=0. rdy with val=0 has no effect.
  - dout = storage[rd_ptr], combinational from registered state. Word order is preserved.
- val/rdy: once val=1, dout stays stable until popped. val does not drop without a pop, except on reset.
- err: sticky until reset. Set only on req withdrawal in WAIT, i.e. the transmitter violated the protocol.
- Reset mid-handshake:
  - ack drops immediately and buffered words are discarded.
  - If req is still high after release, a new handshake starts and din is recaptured. A duplicate word is acceptable; both sides share the system reset.
- Throughput: one word per full 4-phase cycle, which takes a minimum of 6 clk_rx edges plus transmitter-side sync latency.

Test Plan:
- Reset check: hold rst_b=0 with req=1 -> ack=0, val=0, dout=0, err=0. After release, ack=1 on the 3rd edge and dout equals din.
- Single word: DW=8, din=8'hA5, raise req -> ack=1 and val=1 on the 3rd edge, dout=8'hA5. Drop req -> ack=0 three edges later. rdy=1 pops, val=0.
- Back-pressure: DEPTH=2, rdy=0, send 8'h11 and 8'h22 (both acked), then raise req with 8'h33 -> ack stays 0 (WAIT). Pulse rdy for one cycle -> dout=8'h11 popped, 8'h33 written the next cycle, ack=1. Drain order is 22, 33.
- Stream with wrap: rdy=1, send 10 words 8'h00..8'h09 -> all acked, each appears exactly once in order, count never exceeds 1, pointers wrap.
- Protocol violation: FIFO full, raise req then drop it before space frees -> err=1 and stays 1, nothing written, FSM back in IDLE, later handshakes still work.
- Reset mid-operation: assert rst_b=0 while ack=1 and FIFO holds 2 words -> ack, val, count all 0 immediately. Release with req=1 -> word recaptured, ack=1 after 3 edges.
